// File: rtl/pdu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pdu_ctrl_pkg
//   Shared definitions for the PDU run/step/breakpoint sequencer:
//   FSM state encodings, the production debounce length and the helper
//   that sizes the debounce counter.
// ----------------------------------------------------------------------------
package pdu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_BRK  = 2'b11
  } state_t;

  // About 10 ms at 100 MHz; benches override this with a small value.
  localparam int unsigned DB_CYCLES_DEF = 1000000;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input longint unsigned n);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pdu_btn_sync.sv
// ----------------------------------------------------------------------------
// pdu_btn_sync
//   Conditions one raw board input: 2-FF synchronizer, then a debouncer whose
//   output follows the synchronized input only after DB_CYCLES consecutive
//   samples that differ from the current debounced level, plus a one-cycle
//   pulse on each debounced rising edge.
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   raw    in   raw asynchronous input
//   level  out  debounced level
//   rise   out  one-cycle pulse, high in the first cycle level reads 1
// ----------------------------------------------------------------------------
module pdu_btn_sync
  import pdu_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = clog2(longint'(DB_CYCLES) + 64'd1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive samples have disagreed with level; any
  // agreeing sample restarts it, so a bouncing input never gets through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here let meta->sync->level shift as a
      // true pipeline; blocking ones would collapse the stages into one cycle.
      meta <= raw;
      sync <= meta;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync;
        rise  <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pdu_run_ctrl.sv
// ----------------------------------------------------------------------------
// pdu_run_ctrl
//   Run/step/breakpoint sequencer for the pipelined CPU. Produces a single
//   cycle-enable for the CPU clock path and counts enabled cycles.
//   Optional PC breakpoint is built only when PDU_BREAKPOINT_EN is defined;
//   otherwise bp_* inputs are ignored and bp_hit is 0.
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   run      in   raw run switch (level)
//   step     in   raw step button
//   pc       in   current CPU fetch PC
//   bp_we    in   load bp_addr and arm breakpoint
//   bp_clr   in   disarm breakpoint (wins over bp_we)
//   bp_addr  in   breakpoint PC
//   cnt_clr  in   synchronous clear of ce_cnt (wins over increment)
//   cpu_ce   out  CPU cycle enable
//   halted   out  1 in S_STOP or S_BRK
//   state    out  FSM state code
//   bp_hit   out  combinational breakpoint match
//   ce_cnt   out  enabled-cycle count, wraps
// ----------------------------------------------------------------------------
module pdu_run_ctrl
  import pdu_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [31:0]      pc,
  input  logic             bp_we,
  input  logic             bp_clr,
  input  logic [31:0]      bp_addr,
  input  logic             cnt_clr,
  output logic             cpu_ce,
  output logic             halted,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] ce_cnt
);

  state_t st, st_nxt;
  logic   run_db;
  logic   step_p;
  logic   run_rise_unused;
  logic   step_db_unused;

  pdu_btn_sync #(.DB_CYCLES(DB_CYCLES)) u_run_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (run),
    .level (run_db),
    .rise  (run_rise_unused)
  );

  pdu_btn_sync #(.DB_CYCLES(DB_CYCLES)) u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (step),
    .level (step_db_unused),
    .rise  (step_p)
  );

  // -------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_STOP;
    else      st <= st_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    st_nxt = st;
    cpu_ce = 1'b0;
    case (st)
      S_STOP: begin
        if (run_db)      st_nxt = S_RUN;
        else if (step_p) st_nxt = S_STEP;
      end
      S_STEP: begin
        cpu_ce = 1'b1;
        st_nxt = S_STOP;
      end
      S_RUN: begin
        // Hold the CPU in the hit cycle so the instruction at bp_addr waits.
        cpu_ce = !bp_hit;
        if (bp_hit)       st_nxt = S_BRK;
        else if (!run_db) st_nxt = S_STOP;
      end
      S_BRK: begin
        if (step_p)       st_nxt = S_STEP;
        else if (!run_db) st_nxt = S_STOP;
      end
      default: st_nxt = S_STOP;
    endcase
  end

  assign state  = st;
  assign halted = (st == S_STOP) || (st == S_BRK);

  // ------------------------------------------------------- breakpoint
`ifdef PDU_BREAKPOINT_EN
  logic        bp_valid;
  logic        armed;
  logic [31:0] bp_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bp_valid <= 1'b0;
      bp_reg   <= '0;
      armed    <= 1'b0;
    end else begin
      if (bp_we) bp_reg <= bp_addr;
      if (bp_clr)     bp_valid <= 1'b0;
      else if (bp_we) bp_valid <= 1'b1;
      // Disarmed outside S_RUN and during the first run cycle, so resuming
      // at bp_addr executes that instruction once before re-checking.
      armed <= (st == S_RUN) && (armed || cpu_ce);
    end
  end

  assign bp_hit = bp_valid && armed && (st == S_RUN) && (pc == bp_reg);
`else
  logic bp_unused;
  assign bp_unused = ^{bp_we, bp_clr, bp_addr, pc};
  assign bp_hit    = 1'b0;
`endif

  // ---------------------------------------------------- cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ce_cnt <= '0;
    else if (cnt_clr) ce_cnt <= '0;
    else if (cpu_ce)  ce_cnt <= ce_cnt + CNT_W'(1);
  end

endmodule
